// File: rtl/adder64_arbiter.sv
// Round-robin front end sharing one pipelined 64-bit adder between two requesters.
// Results return through a first-word-fall-through FIFO guarded by a credit count.
module adder64_arbiter #(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 6,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [WIDTH-1:0]           req0_a,
    input  logic [WIDTH-1:0]           req0_b,
    input  logic                       req0_cin,
    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [WIDTH-1:0]           req1_a,
    input  logic [WIDTH-1:0]           req1_b,
    input  logic                       req1_cin,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    output logic                       add_cin,
    input  logic [WIDTH-1:0]           add_sum,
    input  logic                       add_cout,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic [WIDTH-1:0]           rsp_sum,
    output logic                       rsp_cout,
    output logic [$clog2(DEPTH+1)-1:0] inflight
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic               can_issue;
    logic               grant0;
    logic               grant1;
    logic               grant;
    logic               last_id;
    logic [LATENCY-1:0] tag_vld;
    logic [LATENCY-1:0] tag_id;
    logic               push;
    logic               pop;
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mem_sum [DEPTH];
    logic               mem_id [DEPTH];
    logic               mem_cout [DEPTH];

    // Credits come from the registered count, so a pop frees a slot only next cycle.
    assign can_issue = rst_n && (inflight < CW'(DEPTH));

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (can_issue) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_id;
                grant1 = !last_id;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign grant      = grant0 || grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (grant0) begin
            add_a   = req0_a;
            add_b   = req0_b;
            add_cin = req0_cin;
        end else if (grant1) begin
            add_a   = req1_a;
            add_b   = req1_b;
            add_cin = req1_cin;
        end
    end

    // Tag stage LATENCY-1 lines up with add_sum/add_cout of the same operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            last_id <= 1'b1;
        end else begin
            tag_vld[0] <= grant;
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
            end
            if (grant) begin
                last_id <= grant1;
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0] <= grant1;
        for (int i = 1; i < LATENCY; i++) begin
            tag_id[i] <= tag_id[i-1];
        end
    end

    assign push      = tag_vld[LATENCY-1];
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_id    = mem_id[rptr];
    assign rsp_sum   = mem_sum[rptr];
    assign rsp_cout  = mem_cout[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_sum[wptr]  <= add_sum;
            mem_id[wptr]   <= tag_id[LATENCY-1];
            mem_cout[wptr] <= add_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            inflight <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
            end
            if (pop) begin
                rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (grant && !pop) begin
                inflight <= inflight + CW'(1);
            end else if (pop && !grant) begin
                inflight <= inflight - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_adder64_arbiter.sv
// Directed bench for adder64_arbiter with a behavioural LATENCY-stage adder that has no reset.
module tb_adder64_arbiter;
    localparam int WIDTH   = 64;
    localparam int LATENCY = 6;
    localparam int DEPTH   = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_cin, req1_cin;
    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_cout;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [WIDTH-1:0] rsp_sum;
    logic [3:0]       inflight;

    int tests = 0;
    int failures = 0;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } vec_t;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } rsp_t;

    rsp_t exp_q[$];

    adder64_arbiter #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .inflight(inflight)
    );

    always #5 clk = ~clk;

    // Shared adder: free-running, no reset, stale contents keep flowing.
    logic [WIDTH:0] apipe [LATENCY];
    always @(posedge clk) begin
        apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        for (int i = 1; i < LATENCY; i++) apipe[i] <= apipe[i-1];
    end
    assign add_sum  = apipe[LATENCY-1][WIDTH-1:0];
    assign add_cout = apipe[LATENCY-1][WIDTH];

    always @(negedge clk) begin
        if (rst_n && dut.push && dut.count == 4'(DEPTH)) begin
            failures++;
            $display("FAIL fifo_overflow: push with count=%0d, required below %0d", dut.count, DEPTH);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string name, output bit ok);
        int w;
        w = 0;
        @(negedge clk);
        while (!rsp_valid && w < 20) begin
            step();
            @(negedge clk);
            w++;
        end
        ok = rsp_valid;
        if (!ok) begin
            tests++;
            failures++;
            $display("FAIL %s: rsp_valid got 0 for 20 cycles, expected 1", name);
        end
    endtask

    task automatic collect(input string name);
        rsp_t r;
        bit   ok;
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            wait_rsp(name, ok);
            if (!ok) begin
                exp_q.delete();
                return;
            end
            check({name, "_id"},   64'(rsp_id),   64'(r.id));
            check({name, "_sum"},  rsp_sum,       r.sum);
            check({name, "_cout"}, 64'(rsp_cout), 64'(r.cout));
            step();
        end
    endtask

    task automatic run_op(input string name, input vec_t v);
        int lat;
        step();
        req0_valid = (v.id == 1'b0);
        req1_valid = (v.id == 1'b1);
        req0_a = v.a; req0_b = v.b; req0_cin = v.cin;
        req1_a = v.a; req1_b = v.b; req1_cin = v.cin;
        @(negedge clk);
        check({name, "_ready"}, 64'(v.id ? req1_ready : req0_ready), 64'(1));
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
            @(negedge clk);
        end
        check({name, "_latency"}, 64'(lat), 64'(LATENCY + 1));
        check({name, "_id"},   64'(rsp_id),   64'(v.id));
        check({name, "_sum"},  rsp_sum,       v.sum);
        check({name, "_cout"}, 64'(rsp_cout), 64'(v.cout));
        step();
        @(negedge clk);
        check({name, "_inflight"}, 64'(inflight), 64'(0));
    endtask

    initial begin
        vec_t vecs[7];
        int   g, bad, first, last, rcnt, grants;

        vecs[0] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1};
        vecs[1] = '{1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0};
        vecs[2] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h8000_0000_0000_0000, 1'b0};
        vecs[3] = '{1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'h1, 1'b1};
        vecs[4] = '{1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0};
        vecs[5] = '{1'b1, 64'h0, 64'h0, 1'b1, 64'h1, 1'b0};
        vecs[6] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 64'd123; req0_b = 64'd7; req0_cin = 1'b1;
        req1_valid = 1'b1; req1_a = 64'd55;  req1_b = 64'd9; req1_cin = 1'b1;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_rsp_valid",  64'(rsp_valid),  64'(0));
        check("reset_req0_ready", 64'(req0_ready), 64'(0));
        check("reset_req1_ready", 64'(req1_ready), 64'(0));
        check("reset_add_a",      add_a,           64'(0));
        check("reset_add_cin",    64'(add_cin),    64'(0));
        check("reset_inflight",   64'(inflight),   64'(0));
        step();
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_op($sformatf("vec%0d", i), vecs[i]);

        // Contention: last grant went to requester 1, so requester 0 wins first.
        for (int k = 0; k < 4; k++) begin
            step();
            req0_valid = 1'b1; req0_a = 64'(k); req0_b = 64'd100; req0_cin = 1'b1;
            req1_valid = 1'b1; req1_a = 64'(k); req1_b = 64'd100; req1_cin = 1'b1;
            @(negedge clk);
            check($sformatf("rr_ready0_c%0d", k), 64'(req0_ready), 64'((k % 2) == 0));
            check($sformatf("rr_ready1_c%0d", k), 64'(req1_ready), 64'((k % 2) == 1));
            exp_q.push_back('{1'((k % 2) == 1), 64'(101 + k), 1'b0});
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        collect("rr_rsp");

        // Backpressure: credits exhaust at DEPTH grants.
        g = 0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            req0_valid = 1'b1; req0_a = 64'(g); req0_b = 64'd1000; req0_cin = 1'b0;
            @(negedge clk);
            if (req0_ready) g++;
        end
        check("bp_grants",   64'(g),          64'(DEPTH));
        check("bp_ready",    64'(req0_ready), 64'(0));
        check("bp_inflight", 64'(inflight),   64'(DEPTH));
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_pop_cycle", 64'(req0_ready), 64'(0));
        check("bp_head_sum",        rsp_sum,         64'd1000);
        step();
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_after_pop", 64'(req0_ready), 64'(1));
        check("bp_inflight_after",  64'(inflight),   64'(DEPTH - 1));
        step();
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 1; k <= 8; k++) exp_q.push_back('{1'b0, 64'(1000 + k), 1'b0});
        collect("bp_drain");

        // Full throughput with requester 1 only.
        grants = 0; rcnt = 0; bad = 0; first = -1; last = -1;
        for (int c = 0; c < 40; c++) begin
            step();
            req1_valid = (c < 20);
            req1_a = 64'h8000_0000_0000_0000; req1_b = 64'h8000_0000_0000_0000; req1_cin = 1'b1;
            @(negedge clk);
            if (req1_ready) grants++;
            if (rsp_valid) begin
                if (first < 0) first = c;
                last = c;
                rcnt++;
                if (rsp_sum !== 64'h1 || rsp_cout !== 1'b1 || rsp_id !== 1'b1) bad++;
            end
        end
        check("tp_grants",      64'(grants),       64'(20));
        check("tp_responses",   64'(rcnt),         64'(20));
        check("tp_first",       64'(first),        64'(LATENCY + 1));
        check("tp_contiguous",  64'(last - first), 64'(19));
        check("tp_bad_payload", 64'(bad),          64'(0));

        // Reset with operations in flight.
        for (int c = 0; c < 3; c++) begin
            step();
            req0_valid = 1'b1; req0_a = 64'(c + 50); req0_b = 64'd3; req0_cin = 1'b0;
            @(negedge clk);
        end
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset_ready",    64'(req0_ready), 64'(0));
        check("mid_reset_add_a",    add_a,           64'(0));
        check("mid_reset_inflight", 64'(inflight),   64'(0));
        step();
        @(negedge clk);
        step();
        rst_n = 1'b1;
        req0_valid = 1'b0;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) step();
            @(negedge clk);
            if (rsp_valid || inflight != 4'd0) bad++;
        end
        check("post_reset_quiet", 64'(bad), 64'(0));
        run_op("post_reset_op", vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at 200000, expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/adder64_arbiter.md
Name: adder64_arbiter

Overview:
- Shares one pipelined 64-bit carry-select prefix adder (LATENCY-cycle, free-running, no stall, no reset) between two requesters.
- Round-robin issue of at most one operation per cycle.
- Tags each in-flight operation with its requester ID.
- Captures adder results into a response FIFO with valid/ready backpressure; a credit counter guarantees no result is ever dropped.

Parameters:
- WIDTH, 64, operand/sum width.
- LATENCY, 6, cycles from operands driven on add_a/add_b/add_cin to the matching result on add_sum/add_cout.
- DEPTH, 8, response FIFO entries. Legal range is DEPTH >= 2. Full throughput requires DEPTH >= LATENCY+2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_cin  in  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  as for requester 0
- add_a, add_b  out  WIDTH  operands to adder
- add_cin  out  1  carry-in to adder
- add_sum  in  WIDTH  adder sum
- add_cout  in  1  adder carry-out
- rsp_valid  out  1  response FIFO head valid
- rsp_ready  in  1  consumer accepts head
- rsp_id  out  1  requester that issued the head op
- rsp_sum  out  WIDTH  head sum
- rsp_cout  out  1  head carry-out
- inflight  out  $clog2(DEPTH+1)  operations issued but not yet popped

Behaviour:
- Reset (rst_n low, asynchronous):
  - Tag pipeline valid bits, FIFO pointers/count and credit counter cleared.
  - RR pointer set so requester 0 wins the first contention.
  - Outputs while reset is low: rsp_valid=0, req0_ready=req1_ready=0, add_a=add_b=0, add_cin=0, inflight=0.
- Credits:
  - Definition: inflight = ops in tag pipeline + FIFO count.
  - can_issue = (inflight < DEPTH).
  - A FIFO pop in cycle t does not raise can_issue until cycle t+1, so there is no combinational rsp_ready-to-req_ready path.
- Arbitration (combinational, each cycle):
  - Only one requester valid and can_issue: grant it.
  - Both valid: grant the one not granted most recently.
  - The RR pointer updates only on a grant.
- Ready and adder inputs:
  - reqN_ready = grantN. A transfer occurs when valid and ready are both 1.
  - On a grant, add_a/add_b/add_cin carry the granted operands in the same cycle.
  - With no grant they are driven to 0. The resulting adder output is ignored.
- Tag pipeline: LATENCY-stage shift register of {valid, id}.
  - Stage 0 is loaded at the clock edge ending grant cycle t.
  - The tag reaches the last stage in cycle t+LATENCY, aligned with add_sum/add_cout for that operation.
  - If the last-stage valid bit is set, {id, add_sum, add_cout} is pushed into the FIFO at the edge ending cycle t+LATENCY.
- Response timing: earliest rsp_valid is cycle t+LATENCY+1, i.e. issue-to-response latency is LATENCY+1 cycles.
- FIFO:
  - First-word-fall-through: rsp_* reflect the head whenever rsp_valid=1.
  - Pop when rsp_valid and rsp_ready. Pointers wrap modulo DEPTH.
  - Simultaneous push and pop keeps the count unchanged, and ordering is preserved.
  - Push when full is impossible by the credit rule. A push while full is a design error and must be flagged by a bench assertion.
- inflight counter: +1 on grant, −1 on pop, unchanged when both occur in the same cycle.
- Ordering: responses leave in global issue order regardless of requester.
- Held operands: a requester holding valid without ready must keep its operands stable. The arbiter does not latch operands.
- Reset mid-operation:
  - All tags and FIFO contents are discarded.
  - Stale adder pipeline contents emerging after reset carry no valid tag and are never pushed.
- Idle: no valid tags, FIFO empty → inflight=0, rsp_valid=0.

Test Plan:
- Single op: after reset, req0 a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, rsp_ready=1 → req0_ready=1 in cycle 0; rsp_valid=1 in cycle 7 with rsp_id=0, sum=0, cout=1; inflight back to 0 in cycle 8.
- Contention: req0 and req1 both held valid for 4 cycles, each issuing a=i, b=100, cin=1 → grants alternate 0,1,0,1; responses in the same order with sums 101+i, cout=0.
- Backpressure: rsp_ready=0, req0 valid continuously → exactly 8 grants; req0_ready then stays 0; inflight=8; after one pop, req0_ready=1 again in the following cycle, not the pop cycle.
- Full throughput: DEPTH=8, rsp_ready=1, 20 back-to-back req1 ops a=0x8000_0000_0000_0000, b=0x8000_0000_0000_0000, cin=1 → one grant per cycle; 20 responses on consecutive cycles with sum=1, cout=1.
- Reset mid-flight: issue 3 ops, assert rst_n low in cycle 3 for 2 cycles → rsp_valid stays 0 for at least 10 cycles after release; inflight=0; a new op then returns correctly after 7 cycles.
- Carry-select boundary: a=0x0000_0000_FFFF_FFFF, b=1, cin=0 → sum=0x0000_0001_0000_0000, cout=0; a=0x7FFF_FFFF_FFFF_FFFF, b=0, cin=1 → sum=0x8000_0000_0000_0000.
